// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU, debug-port and external RAM signals of the memory arbiter.
interface mem_arbiter_if;
    logic        i_cpuAccess;
    logic [16:0] i_cpuAddress;
    logic [7:0]  i_cpuData;
    logic        i_cpuWE;
    logic [7:0]  o_cpuData;
    logic        o_cpuHoldN;
    logic        i_dbgReq;
    logic        i_dbgWE;
    logic [16:0] i_dbgAddress;
    logic [7:0]  i_dbgData;
    logic        o_dbgAck;
    logic [7:0]  o_dbgData;
    logic [16:0] o_ramAddress;
    logic [7:0]  o_ramData;
    logic        o_ramWE;
    logic [7:0]  i_ramData;
    modport slave (
        input  i_cpuAccess, i_cpuAddress, i_cpuData, i_cpuWE, i_dbgReq, i_dbgWE,
               i_dbgAddress, i_dbgData, i_ramData,
        output o_cpuData, o_cpuHoldN, o_dbgAck, o_dbgData, o_ramAddress, o_ramData, o_ramWE
    );
    modport master (
        output i_cpuAccess, i_cpuAddress, i_cpuData, i_cpuWE, i_dbgReq, i_dbgWE,
               i_dbgAddress, i_dbgData, i_ramData,
        input  o_cpuData, o_cpuHoldN, o_dbgAck, o_dbgData, o_ramAddress, o_ramData, o_ramWE
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external RAM between a CPU and a four-phase debug port,
// forcing the CPU off after a bounded number of denied debug cycles.
module mem_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 8
) (
    input logic          i_clk,
    input logic          i_reset,
    mem_arbiter_if.slave io_bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
    localparam logic [3:0] LAST  = 4'(ACCESS_CYCLES - 1);
    state_t      r_state, w_next;
    logic [7:0]  r_starve;
    logic [3:0]  r_cyc;
    logic        r_we;
    logic [16:0] r_addr;
    logic [7:0]  r_data;
    logic [7:0]  r_dbg_data;
    logic        w_grant;
    logic        w_last;
    assign w_grant = r_state == IDLE && io_bus.i_dbgReq && (!io_bus.i_cpuAccess || r_starve == LIMIT);
    assign w_last  = r_cyc == LAST;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end
    always_comb begin
        w_next = r_state == IDLE   ? (w_grant ? ACCESS : IDLE) :
                 r_state == ACCESS ? (w_last ? DONE : ACCESS) :
                 (io_bus.i_dbgReq ? DONE : IDLE);
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_starve   <= '0;
            r_cyc      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_dbg_data <= '0;
        end else begin
            if (r_state == IDLE)
                r_starve <= (w_grant || !io_bus.i_dbgReq) ? 8'd0 :
                            (io_bus.i_cpuAccess && r_starve < LIMIT) ? r_starve + 8'd1 : r_starve;
            if (w_grant) begin
                r_cyc  <= '0;
                r_we   <= io_bus.i_dbgWE;
                r_addr <= io_bus.i_dbgAddress;
                r_data <= io_bus.i_dbgData;
            end
            if (r_state == ACCESS) r_cyc <= r_cyc + 4'd1;
            if (r_state == ACCESS && w_last && !r_we) r_dbg_data <= io_bus.i_ramData;
        end
    end
    // the final ACCESS cycle is a hold cycle: address stays, write strobe drops
    always_comb begin
        io_bus.o_ramAddress = r_state == IDLE ? io_bus.i_cpuAddress : r_addr;
        io_bus.o_ramData    = r_state == IDLE ? io_bus.i_cpuData : r_data;
        io_bus.o_ramWE      = r_state == IDLE   ? io_bus.i_cpuAccess & io_bus.i_cpuWE :
                              r_state == ACCESS ? r_we & ~w_last : 1'b0;
        io_bus.o_cpuData    = io_bus.i_ramData;
        io_bus.o_cpuHoldN   = r_state == IDLE;
        io_bus.o_dbgAck     = r_state == DONE;
        io_bus.o_dbgData    = r_dbg_data;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives two arbiters (2- and 4-cycle access) with shared stimulus against a transaction-level model.
module tb_mem_arbiter;
    localparam int LIM = 8;
    localparam int ACS [2] = '{2, 4};
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic        cpu_acc = 1'b0, cpu_we = 1'b0, req = 1'b0, dbg_we = 1'b0;
    logic [16:0] cpu_addr = '0, dbg_addr = '0;
    logic [7:0]  cpu_wd = '0, dbg_wd = '0;
    logic [16:0] ram_addr [2];
    logic [7:0]  ram_wd [2], cpu_rd [2], dbg_rd [2];
    logic        ram_we [2], hold [2], ack [2];
    bit [7:0]    ram [2][131072];
    bit [7:0]    mm [2][131072];
    int          n_cmp = 0, n_bad = 0;
    for (genvar k = 0; k < 2; k++) begin : g
        mem_arbiter_if ifc ();
        assign ifc.i_cpuAccess  = cpu_acc;
        assign ifc.i_cpuAddress = cpu_addr;
        assign ifc.i_cpuData    = cpu_wd;
        assign ifc.i_cpuWE      = cpu_we;
        assign ifc.i_dbgReq     = req;
        assign ifc.i_dbgWE      = dbg_we;
        assign ifc.i_dbgAddress = dbg_addr;
        assign ifc.i_dbgData    = dbg_wd;
        assign ifc.i_ramData    = ram[k][ifc.o_ramAddress];
        assign ram_addr[k] = ifc.o_ramAddress;
        assign ram_wd[k]   = ifc.o_ramData;
        assign ram_we[k]   = ifc.o_ramWE;
        assign cpu_rd[k]   = ifc.o_cpuData;
        assign dbg_rd[k]   = ifc.o_dbgData;
        assign hold[k]     = ifc.o_cpuHoldN;
        assign ack[k]      = ifc.o_dbgAck;
        mem_arbiter #(.ACCESS_CYCLES(ACS[k]), .STARVE_LIMIT(LIM)) dut (
            .i_clk(clk), .i_reset(rst), .io_bus(ifc)
        );
    end
    always @(posedge clk)
        for (int k = 0; k < 2; k++) if (ram_we[k]) ram[k][ram_addr[k]] <= ram_wd[k];
    // model: a transaction is "active" from grant until the ack is released; el counts cycles since grant
    bit        act [2];
    int        el [2], st [2];
    bit        wel [2];
    bit [16:0] al [2];
    bit [7:0]  dl [2], dq [2];
    always @(posedge clk or posedge rst)
        for (int k = 0; k < 2; k++)
            if (rst) begin
                act[k] <= 0; el[k] <= 0; st[k] <= 0; wel[k] <= 0; al[k] <= 0; dl[k] <= 0; dq[k] <= 0;
            end else if (!act[k]) begin
                if (cpu_acc && cpu_we) mm[k][cpu_addr] <= cpu_wd;
                if (req && (!cpu_acc || st[k] == LIM)) begin
                    act[k] <= 1; el[k] <= 0; st[k] <= 0;
                    wel[k] <= dbg_we; al[k] <= dbg_addr; dl[k] <= dbg_wd;
                end else st[k] <= !req ? 0 : (st[k] < LIM ? st[k] + 1 : st[k]);
            end else if (el[k] < ACS[k]) begin
                if (wel[k] && el[k] < ACS[k] - 1) mm[k][al[k]] <= dl[k];
                if (!wel[k] && el[k] == ACS[k] - 1) dq[k] <= mm[k][al[k]];
                el[k] <= el[k] + 1;
            end else if (!req) act[k] <= 0;
    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, k, got, want, $time);
        end
    endtask
    task automatic compare();
        for (int k = 0; k < 2; k++) begin
            bit idle, acc;
            bit [16:0] ea;
            idle = !act[k];
            acc  = act[k] && el[k] < ACS[k];
            ea   = idle ? cpu_addr : al[k];
            chk("ramAddress", k, ram_addr[k], ea);
            if (idle || acc) chk("ramData", k, ram_wd[k], idle ? cpu_wd : dl[k]);
            chk("ramWE", k, ram_we[k], idle ? cpu_acc & cpu_we : acc && wel[k] && el[k] < ACS[k] - 1);
            chk("cpuHoldN", k, hold[k], idle);
            chk("dbgAck", k, ack[k], act[k] && !acc);
            chk("dbgData", k, dbg_rd[k], dq[k]);
            chk("cpuData", k, cpu_rd[k], mm[k][ea]);
        end
    endtask
    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_ack(input int k);
        int n = 0;
        while (!ack[k] && n < 40) begin
            step();
            n++;
        end
        chk("ackWait", k, ack[k], 1);
    endtask
    initial begin
        int n, w0, w1, a0, a1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rstAck", k, ack[k], 0);
            chk("rstHoldN", k, hold[k], 1);
            chk("rstDbgData", k, dbg_rd[k], 0);
        end
        cpu_acc = 1; cpu_we = 1; cpu_addr = 17'h10042; cpu_wd = 8'h99;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rstRamWE", k, ram_we[k], 1);
            chk("rstRamAddr", k, ram_addr[k], 17'h10042);
        end
        cpu_acc = 0; cpu_we = 0;
        #1 rst = 0;
        step();
        req = 1; dbg_we = 1; dbg_addr = 17'h00123; dbg_wd = 8'h5A;
        step();
        chk("wrWE1", 0, ram_we[0], 1);
        chk("wrHold", 0, hold[0], 0);
        chk("wrAddr", 0, ram_addr[0], 17'h00123);
        step();
        chk("wrWE2", 0, ram_we[0], 0);
        chk("wrAckEarly", 0, ack[0], 0);
        step();
        chk("wrAck", 0, ack[0], 1);
        chk("wrHoldDone", 0, hold[0], 0);
        wait_ack(1);
        req = 0;
        step();
        for (int k = 0; k < 2; k++) chk("wrIdleHold", k, hold[k], 1);
        dbg_we = 0; req = 1;
        wait_ack(0);
        wait_ack(1);
        for (int k = 0; k < 2; k++) chk("readBack", k, dbg_rd[k], 8'h5A);
        req = 0;
        step();
        cpu_acc = 1; cpu_addr = 17'h00200; req = 1;
        n = 0;
        do begin
            step();
            n++;
        end while (hold[0] && n < 20);
        chk("starveEdges", 0, n, 9);
        chk("starveHold", 1, hold[1], 0);
        wait_ack(0);
        wait_ack(1);
        req = 0; cpu_acc = 0;
        step();
        req = 1; cpu_acc = 1; cpu_addr = 17'h10033;
        repeat (5) begin
            step();
            chk("contAck", 0, ack[0], 0);
            chk("contHold", 0, hold[0], 1);
            chk("contAddr", 0, ram_addr[0], 17'h10033);
        end
        cpu_acc = 0;
        step();
        chk("contGrant", 0, hold[0], 0);
        wait_ack(0);
        wait_ack(1);
        req = 0;
        step();
        req = 1; dbg_we = 1; dbg_addr = 17'h00456; dbg_wd = 8'hC3;
        step();
        req = 0;
        w0 = 0; w1 = 0; a0 = 0; a1 = 0;
        repeat (8) begin
            w0 += int'(ram_we[0]); w1 += int'(ram_we[1]);
            a0 += int'(ack[0]);    a1 += int'(ack[1]);
            step();
        end
        chk("dropWE", 0, w0, 1);
        chk("dropWE", 1, w1, 3);
        chk("dropAck", 0, a0, 1);
        chk("dropAck", 1, a1, 1);
        for (int k = 0; k < 2; k++) chk("dropIdle", k, hold[k], 1);
        req = 1; dbg_we = 1; dbg_addr = 17'h00789; dbg_wd = 8'h11;
        step();
        chk("abortWE", 1, ram_we[1], 1);
        #2 rst = 1; req = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("asyncWE", k, ram_we[k], 0);
            chk("asyncHold", k, hold[k], 1);
            chk("asyncDbg", k, dbg_rd[k], 0);
            chk("asyncAck", k, ack[k], 0);
        end
        step();
        rst = 0;
        repeat (5) begin
            step();
            for (int k = 0; k < 2; k++) chk("postRstAck", k, ack[k], 0);
        end
        for (int k = 0; k < 2; k++) chk("noRetry", k, ram[k][17'h00789], 0);
        for (int i = 0; i < 3000; i++) begin
            cpu_acc  = i < 1500 ? $urandom_range(0, 7) != 0 : $urandom_range(0, 1) == 1;
            cpu_we   = $urandom_range(0, 1) == 1;
            cpu_addr = {1'($urandom_range(0, 1)), 10'd0, 6'($urandom_range(0, 63))};
            cpu_wd   = 8'($urandom);
            dbg_we   = $urandom_range(0, 1) == 1;
            dbg_addr = {1'($urandom_range(0, 1)), 10'd0, 6'($urandom_range(0, 63))};
            dbg_wd   = 8'($urandom);
            if (!req) req = $urandom_range(0, 3) == 0;
            else if (ack[0] && ack[1]) req = $urandom_range(0, 1) == 1;
            else if ($urandom_range(0, 29) == 0) req = 0;
            if ($urandom_range(0, 599) == 0) begin
                rst = 1;
                cpu_acc = 0;
            end else rst = 0;
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
